// File: rtl/map_pkg.sv
// Shared types and constants for the MAP decoder frame scheduler.
// Holds the scheduler state enum, width defaults and direction encodings.
package map_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int ITER_W_DEF = 4;

  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_BWD = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT_F,
    S_FWD,
    S_INIT_B,
    S_BWD,
    S_DONE
  } state_e;

endpackage

// File: rtl/map_step_cnt.sv
// Up/down loadable trellis-step counter with saturating terminal flag.
// Ports: clr/load/en controls, up direction, last (N-1), cnt value, term flag.
module map_step_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic         up,
  input  logic [W-1:0] last,
  output logic [W-1:0] cnt,
  output logic         term
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Terminal address: N-1 going up, 0 going down.
  assign term = up ? (cnt_q == last) : (cnt_q == '0);

  // At the terminal address the counter holds; the pass change is
  // handled by the scheduler via load.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (en && !term) begin
      cnt_d = up ? cnt_q + W'(1) : cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/map_sched.sv
// Frame scheduler: forward/backward trellis passes over max_iter iterations.
// Ports: start/abort/frame_len/max_iter/step_done in; stage control and status out.
module map_sched
  import map_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int ITER_W = ITER_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] frame_len,
  input  logic [ITER_W-1:0] max_iter,
  input  logic              step_done,
  output logic              init_metrics,
  output logic              step_req,
  output logic [ADDR_W-1:0] ad_addr,
  output logic              w_r,
  output logic              dir,
  output logic              llr_en,
  output logic [ITER_W-1:0] iter,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_e state_q, state_d;

  logic [ADDR_W-1:0] n_q, n_d;
  logic [ITER_W-1:0] mi_q, mi_d;
  logic [ITER_W-1:0] iter_q, iter_d;

  logic init_q, init_d;
  logic req_q, req_d;
  logic wr_q, wr_d;
  logic dir_q, dir_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic err_q, err_d;

  logic              cnt_clr;
  logic              cnt_load;
  logic [ADDR_W-1:0] cnt_val;
  logic              cnt_en;
  logic              cnt_up;
  logic              cnt_term;
  logic [ADDR_W-1:0] cnt;
  logic              hs;

  assign hs     = req_q & step_done;
  assign cnt_up = (state_q == S_FWD);

  map_step_cnt #(
    .W(ADDR_W)
  ) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr     (cnt_clr),
    .load    (cnt_load),
    .load_val(cnt_val),
    .en      (cnt_en),
    .up      (cnt_up),
    .last    (n_q - ADDR_W'(1)),
    .cnt     (cnt),
    .term    (cnt_term)
  );

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    mi_d     = mi_q;
    iter_d   = iter_q;
    err_d    = 1'b0;
    cnt_clr  = 1'b0;
    cnt_load = 1'b0;
    cnt_val  = '0;
    cnt_en   = 1'b0;
    if (abort) begin
      state_d = S_IDLE;
      iter_d  = '0;
      cnt_clr = 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            if (frame_len == '0) begin
              err_d = 1'b1;
            end else begin
              n_d     = frame_len;
              mi_d    = (max_iter == '0) ? ITER_W'(1) : max_iter;
              iter_d  = '0;
              cnt_clr = 1'b1;
              state_d = S_INIT_F;
            end
          end
        end
        S_INIT_F: state_d = S_FWD;
        S_FWD: begin
          if (hs) begin
            if (cnt_term) begin
              // Preload N-1 so INIT_B already shows it.
              cnt_load = 1'b1;
              cnt_val  = n_q - ADDR_W'(1);
              state_d  = S_INIT_B;
            end else begin
              cnt_en = 1'b1;
            end
          end
        end
        S_INIT_B: state_d = S_BWD;
        S_BWD: begin
          if (hs) begin
            if (cnt_term) begin
              if (iter_q == mi_q - ITER_W'(1)) begin
                state_d = S_DONE;
              end else begin
                iter_d   = iter_q + ITER_W'(1);
                cnt_load = 1'b1;
                cnt_val  = '0;
                state_d  = S_INIT_F;
              end
            end else begin
              cnt_en = 1'b1;
            end
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs are registered: decode them from the next state.
  always_comb begin
    init_d = (state_d == S_INIT_F) || (state_d == S_INIT_B);
    req_d  = (state_d == S_FWD) || (state_d == S_BWD);
    wr_d   = (state_d == S_INIT_F) || (state_d == S_FWD);
    dir_d  = ((state_d == S_INIT_B) || (state_d == S_BWD))
             ? DIR_BWD : DIR_FWD;
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      mi_q    <= '0;
      iter_q  <= '0;
      init_q  <= 1'b0;
      req_q   <= 1'b0;
      wr_q    <= 1'b0;
      dir_q   <= DIR_FWD;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      mi_q    <= mi_d;
      iter_q  <= iter_d;
      init_q  <= init_d;
      req_q   <= req_d;
      wr_q    <= wr_d;
      dir_q   <= dir_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign init_metrics = init_q;
  assign step_req     = req_q;
  assign ad_addr      = cnt;
  assign w_r          = wr_q;
  assign dir          = dir_q;
  assign llr_en       = req_q & step_done & dir_q;
  assign iter         = iter_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;

endmodule

// File: tb/tb_map_sched.sv
// Directed testbench for map_sched.
// Each task drives one scenario and checks outputs against hand-derived values.
module tb_map_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] frame_len = '0;
  logic [3:0] max_iter = '0;
  logic       step_done = 1'b0;
  logic       init_metrics;
  logic       step_req;
  logic [7:0] ad_addr;
  logic       w_r;
  logic       dir;
  logic       llr_en;
  logic [3:0] iter;
  logic       busy;
  logic       done;
  logic       err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  map_sched dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .frame_len   (frame_len),
    .max_iter    (max_iter),
    .step_done   (step_done),
    .init_metrics(init_metrics),
    .step_req    (step_req),
    .ad_addr     (ad_addr),
    .w_r         (w_r),
    .dir         (dir),
    .llr_en      (llr_en),
    .iter        (iter),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  function automatic logic [7:0] flags();
    return {init_metrics, step_req, w_r, dir, llr_en, busy, done, err};
  endfunction

  task automatic launch(input logic [7:0] n, input logic [3:0] mi,
                        input logic sd);
    @(posedge clk); #1;
    start = 1'b1;
    frame_len = n;
    max_iter = mi;
    step_done = sd;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #12;
    checks++;
    if (flags() !== 8'h00) begin
      errors++;
      $display("FAIL reset_flags got %b want %b", flags(), 8'h00);
    end
    checks++;
    if (ad_addr !== 8'd0 || iter !== 4'd0) begin
      errors++;
      $display("FAIL reset_regs got addr=%0d iter=%0d want 0/0", ad_addr, iter);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_basic();
    logic [7:0] ef;
    logic [7:0] ea;
    launch(8'd4, 4'd1, 1'b1);
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      #1;
      // {init,req,wr,dir,llr,busy,done,err}
      if (k == 1) begin
        ef = 8'b1010_0100; ea = 8'd0;
      end else if (k <= 5) begin
        ef = 8'b0110_0100; ea = 8'(k - 2);
      end else if (k == 6) begin
        ef = 8'b1001_0100; ea = 8'd3;
      end else if (k <= 10) begin
        ef = 8'b0101_1100; ea = 8'(10 - k);
      end else if (k == 11) begin
        ef = 8'b0000_0110; ea = 8'd0;
      end else begin
        ef = 8'b0000_0000; ea = 8'd0;
      end
      checks++;
      if (flags() !== ef) begin
        errors++;
        $display("FAIL basic_flags k=%0d got %b want %b", k, flags(), ef);
      end
      checks++;
      if (ad_addr !== ea) begin
        errors++;
        $display("FAIL basic_addr k=%0d got %0d want %0d", k, ad_addr, ea);
      end
    end
    step_done = 1'b0;
  endtask

  task automatic test_stall();
    int hs = 0;
    int llr = 0;
    int dn = 0;
    logic [7:0] ea;
    launch(8'd3, 4'd1, 1'b0);
    for (int c = 0; c < 60 && dn == 0; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      step_done = (c % 3 == 2);
      #1;
      if (step_req) begin
        ea = (hs < 3) ? 8'(hs) : 8'(5 - hs);
        checks++;
        if (ad_addr !== ea || dir !== (hs >= 3)) begin
          errors++;
          $display("FAIL stall_addr hs=%0d got %0d/%b want %0d/%b",
                   hs, ad_addr, dir, ea, (hs >= 3));
        end
        if (step_done) hs++;
      end
      if (llr_en) llr++;
      if (done) dn++;
    end
    step_done = 1'b0;
    checks++;
    if (dn !== 1 || hs !== 6 || llr !== 3) begin
      errors++;
      $display("FAIL stall_counts got done=%0d hs=%0d llr=%0d want 1/6/3",
               dn, hs, llr);
    end
  endtask

  task automatic test_iterations();
    int bc;
    int ic;
    int dc;
    int di;
    int eb;
    int ei;
    int edi;
    logic [3:0] seq [8];
    for (int cfg = 0; cfg < 2; cfg++) begin
      bc = 0; ic = 0; dc = 0; di = -1;
      eb = (cfg == 0) ? 19 : 7;
      ei = (cfg == 0) ? 6 : 2;
      edi = (cfg == 0) ? 2 : 0;
      launch(8'd2, (cfg == 0) ? 4'd3 : 4'd0, 1'b1);
      for (int k = 1; k <= 24; k++) begin
        @(posedge clk); #1;
        start = 1'b0;
        #1;
        if (busy) bc++;
        if (init_metrics) begin
          if (ic < 8) seq[ic] = iter;
          ic++;
        end
        if (done) begin
          dc++;
          di = int'(iter);
        end
      end
      checks++;
      if (bc !== eb || ic !== ei || dc !== 1 || di !== edi) begin
        errors++;
        $display("FAIL iter_counts cfg=%0d got busy=%0d init=%0d done=%0d it=%0d want %0d/%0d/1/%0d",
                 cfg, bc, ic, dc, di, eb, ei, edi);
      end
      for (int i = 0; i < ei && i < ic; i++) begin
        checks++;
        if (seq[i] !== 4'(i / 2)) begin
          errors++;
          $display("FAIL iter_seq cfg=%0d i=%0d got %0d want %0d",
                   cfg, i, seq[i], i / 2);
        end
      end
    end
    step_done = 1'b0;
  endtask

  task automatic test_error();
    launch(8'd0, 4'd1, 1'b0);
    @(posedge clk); #1;
    start = 1'b0;
    #1;
    checks++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL err_pulse got err=%b busy=%b want 1/0", err, busy);
    end
    @(posedge clk); #2;
    checks++;
    if (err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL err_clear got err=%b busy=%b want 0/0", err, busy);
    end
  endtask

  task automatic test_ignore();
    int bc = 0;
    int dk = 0;
    int dc = 0;
    launch(8'd4, 4'd1, 1'b1);
    for (int k = 1; k <= 13; k++) begin
      @(posedge clk); #1;
      start = (k == 4);
      if (k == 4) begin
        frame_len = 8'd2;
        max_iter = 4'd2;
      end
      #1;
      if (busy) bc++;
      if (done) begin
        dc++;
        dk = k;
      end
    end
    start = 1'b0;
    step_done = 1'b0;
    checks++;
    if (bc !== 11 || dk !== 11 || dc !== 1) begin
      errors++;
      $display("FAIL ignore_start got busy=%0d done_k=%0d done_n=%0d want 11/11/1",
               bc, dk, dc);
    end
  endtask

  task automatic test_abort();
    int dc = 0;
    int bc = 0;
    int dk = 0;
    launch(8'd4, 4'd1, 1'b1);
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      #1;
    end
    checks++;
    if (ad_addr !== 8'd1 || dir !== 1'b1 || step_req !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre got addr=%0d dir=%b req=%b want 1/1/1",
               ad_addr, dir, step_req);
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || ad_addr !== 8'd0 || step_req !== 1'b0 ||
        done !== 1'b0 || iter !== 4'd0) begin
      errors++;
      $display("FAIL abort_idle got busy=%b addr=%0d req=%b done=%b iter=%0d want 0/0/0/0/0",
               busy, ad_addr, step_req, done, iter);
    end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #2;
      if (done || busy) dc++;
    end
    checks++;
    if (dc !== 0) begin
      errors++;
      $display("FAIL abort_quiet got %0d active cycles want 0", dc);
    end
    launch(8'd2, 4'd1, 1'b1);
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      #1;
      if (busy) bc++;
      if (done) dk = k;
    end
    step_done = 1'b0;
    checks++;
    if (bc !== 7 || dk !== 7) begin
      errors++;
      $display("FAIL abort_restart got busy=%0d done_k=%0d want 7/7", bc, dk);
    end
  endtask

  task automatic test_async_reset();
    int bad = 0;
    launch(8'd4, 4'd1, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      #1;
    end
    checks++;
    if (step_req !== 1'b1 || ad_addr !== 8'd1) begin
      errors++;
      $display("FAIL areset_pre got req=%b addr=%0d want 1/1", step_req, ad_addr);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (flags() !== 8'h00 || ad_addr !== 8'd0 || iter !== 4'd0) begin
      errors++;
      $display("FAIL areset_now got flags=%b addr=%0d iter=%0d want 0/0/0",
               flags(), ad_addr, iter);
    end
    @(negedge clk);
    rst = 1'b1;
    step_done = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #2;
      if (busy || step_req || init_metrics || ad_addr != 8'd0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL areset_idle got %0d active cycles want 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_iterations();
    test_error();
    test_ignore();
    test_abort();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/map_sched.md
# map_sched

Frame-level scheduler for the MAP decoder trellis datapath. It sequences the shared 8-state metric stage through a forward (alpha) pass and a backward (beta/LLR) pass over one frame, repeated for a programmable number of iterations. It drives the stage's step address, alpha-memory write/read select and per-step handshake, and reports completion upward to the decoder top level.

## Interface
- ADDR_W, 8, trellis-step address width; frames are up to 2^ADDR_W−1 steps.
- ITER_W, 4, iteration counter width.
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that launches a frame; ignored while busy=1.
- abort  in  1  synchronous cancel; overrides every other input except rst.
- frame_len  in  ADDR_W  number of trellis steps N, latched at start.
- max_iter  in  ITER_W  iterations per frame, latched at start; 0 is treated as 1.
- step_done  in  1  metric stage finished the current step; ignored when step_req=0.
- init_metrics  out  1  one-cycle pulse that loads the stage's initial state metrics before each pass.
- step_req  out  1  request that the stage process step ad_addr.
- ad_addr  out  ADDR_W  current trellis-step address.
- w_r  out  1  1 = write alpha memory (forward pass), 0 = read (backward pass).
- dir  out  1  0 = forward, 1 = backward.
- llr_en  out  1  LLR output valid qualifier, equal to step_req & step_done & dir.
- iter  out  ITER_W  current iteration index, starting at 0.
- busy  out  1  high from the cycle after start through the DONE cycle.
- done  out  1  one-cycle pulse at frame completion.
- err  out  1  one-cycle pulse when start arrives with frame_len=0.

## Operation
- States: IDLE, INIT_F, FWD, INIT_B, BWD, DONE.
- IDLE:
  - start with frame_len≠0: latch N and max_iter, clear iter, go to INIT_F.
  - start with frame_len=0: pulse err, stay in IDLE.
- INIT_F: init_metrics=1, ad_addr=0, dir=0, w_r=1; next state FWD.
- FWD:
  - step_req=1, w_r=1.
  - On step_req&step_done: if ad_addr=N−1, go to INIT_B; otherwise ad_addr+1.
- INIT_B: init_metrics=1, ad_addr=N−1, dir=1, w_r=0; next state BWD.
- BWD:
  - step_req=1, w_r=0, llr_en per its definition.
  - On handshake at ad_addr=0: if iter=max_iter−1, go to DONE; otherwise iter+1 and go to INIT_F.
  - Otherwise ad_addr−1.
- DONE: done=1, busy=1; next state IDLE.
- abort in any non-IDLE state: next state IDLE, no done pulse, iter and ad_addr cleared.
- Address counter never wraps: forward saturates at N−1, backward stops at 0. The handshake at the terminal address changes state; it does not change the address.
- start and abort together in IDLE: abort wins, stay in IDLE.

## Timing
- Reset values: state IDLE; ad_addr=0, iter=0, w_r=0, dir=0, step_req=0, init_metrics=0, llr_en=0, busy=0, done=0, err=0.
- start at cycle t → INIT_F at t+1 (busy=1, init_metrics=1) → step_req=1 with ad_addr=0 at t+2.
- Back-to-back steps: step_req stays high across steps. A handshake in cycle c presents the next address at c+1, so one step per cycle is possible.
- Each pass boundary costs exactly one INIT cycle with step_req=0.
- With step_done tied high: total busy cycles = max_iter·(2N+2)+1.
- done rises one cycle after the final backward handshake and is high for exactly one cycle. busy falls in the cycle after done.
- All outputs are registered except llr_en, which is combinational from registered step_req/dir and the step_done input.

## Structure
- Shared package map_pkg holds:
  - the state enum;
  - ADDR_W and ITER_W defaults;
  - DIR_FWD/DIR_BWD constants.
- Sub-module map_step_cnt: up/down loadable ADDR_W counter with enable, load value and terminal flag (ad_addr=N−1 going up, 0 going down). Used once for ad_addr.

## Test plan
- Basic frame: N=4, max_iter=1, step_done tied high.
  - Expect ad_addr 0,1,2,3 with w_r=1, then 3,2,1,0 with w_r=0 and llr_en high four cycles.
  - Expect done at cycle t+11; busy high for 11 cycles.
- Stalled handshake: N=3, step_done high only every third cycle.
  - Address advances only on handshake; no address skipped or repeated; exactly 3 llr_en pulses.
- Iterations: N=2, max_iter=3.
  - iter steps 0→1→2; init_metrics pulses 6 times; single done after iter=2 backward pass.
  - Repeat with max_iter=0: behaves as 1 iteration.
- Error and ignore: start with frame_len=0 gives err for 1 cycle, busy stays 0. Start issued mid-frame is ignored; frame completes unchanged.
- Abort during BWD at ad_addr=1: IDLE next cycle, ad_addr=0, no done. A fresh start then runs normally.
- Asynchronous reset asserted mid-FWD between clock edges: all outputs take reset values immediately. After release, the block is idle until start.
